snes_rst_seq: RTL and testbench
===============================

SNES_RST_SEQ -- requirements
Module: snes_rst_seq

Interface
REQ-001 The block SHALL have parameter POR_CYCLES, default 864000, meaning power-on hold of 10 ms at 86.4 MHz.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 1024, meaning the core reset pulse width in cycles.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 432000, meaning how long the button must stay stable before a level change is accepted.
REQ-004 The block SHALL have parameter WDT_CYCLES, default 8640000, meaning the SDRAM-init timeout (watchdog build only).
REQ-005 Port: clk  in  1  SNES master clock from the PLL CLKOUT; single clock domain.
REQ-006 Port: rst  in  1  reset, asynchronous and active-high (driven from PLL not-locked).
REQ-007 Port: sdram_init_done  in  1  level, SDRAM controller initialisation complete.
REQ-008 Port: loading  in  1  level, cartridge ROM download in progress.
REQ-009 Port: btn_reset  in  1  raw asynchronous user reset button, active-high.
REQ-010 Port: sdram_rst  out  1  active-high reset to the SDRAM controller.
REQ-011 Port: core_rst  out  1  active-high reset to the SNES core.
REQ-012 Port: core_ready  out  1  high only in state RUN.
REQ-013 Port: state  out  3  current state: POR=0, SDRAM_INIT=1, LOAD=2, HOLD=3, RUN=4.
REQ-014 Port: sdram_retry  out  4  saturating count of watchdog restarts.

Function
REQ-015 All outputs SHALL be registered; parameters SHALL be checked by a 24-bit cycle counter, which is cleared on every state entry.
REQ-016 POR: sdram_rst=1, core_rst=1; after POR_CYCLES cycles in POR, next state SHALL be SDRAM_INIT, with sdram_rst=0 from the first SDRAM_INIT cycle.
REQ-017 SDRAM_INIT: core_rst=1; sdram_init_done=1 SHALL move to LOAD on the next edge.
REQ-018 LOAD: core_rst=1; loading=0 SHALL move to HOLD on the next edge (no ROM load also passes straight through).
REQ-019 HOLD: core_rst=1 for exactly HOLD_CYCLES cycles, then RUN.
REQ-020 RUN: core_rst=0, core_ready=1; loading=1 SHALL move to LOAD; a debounced press event SHALL move to HOLD.
REQ-021 In RUN, if loading=1 and a press event occur in the same cycle, the block SHALL move to LOAD.
REQ-022 A press event outside RUN SHALL be discarded.
REQ-023 sdram_init_done falling in LOAD/HOLD/RUN SHALL move to SDRAM_INIT with core_rst=1.
REQ-024 Debounce: btn_reset SHALL pass a 2-flop synchroniser; the debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; a press event is a one-cycle pulse on the debounced 0->1 edge.
REQ-025 Latency: button input edge to HOLD entry SHALL be DEBOUNCE_CYCLES+3 cycles.

Reset
REQ-026 While rst=1, the block SHALL be forced immediately (asynchronously) to: state=POR, sdram_rst=1, core_rst=1, core_ready=0, counter=0, sdram_retry=0, debounced level=0, synchroniser=0.
REQ-027 rst asserted mid-operation (any state) SHALL restart the full sequence from POR after release.

Configuration
REQ-028 With macro RST_SEQ_WATCHDOG_EN defined, if SDRAM_INIT exceeds WDT_CYCLES cycles the block SHALL return to POR (sdram_rst=1 next cycle) and increment sdram_retry, saturating at 15.
REQ-029 Without RST_SEQ_WATCHDOG_EN, SDRAM_INIT SHALL wait indefinitely and sdram_retry SHALL be constant 0.

Verification (POR_CYCLES=16, HOLD_CYCLES=8, DEBOUNCE_CYCLES=4, WDT_CYCLES=64)
REQ-030 rst pulse, sdram_init_done=1, loading=0 -> sdram_rst falls 16 cycles after release; core_rst falls and core_ready rises after further 1+1+8 cycles.
REQ-031 In RUN: btn_reset high for 3 cycles -> no change; held high for 10 cycles -> HOLD entered 7 cycles after rise, core_rst=1 for 8 cycles.
REQ-032 In RUN: loading=1 plus press event in the same cycle -> state=2; loading drops -> HOLD 8 cycles -> RUN.
REQ-033 rst asserted in HOLD -> all outputs at reset values in the same cycle, with no clock edge required.
REQ-034 Watchdog build, sdram_init_done tied 0 -> POR re-entered every 16+64 cycles; sdram_retry counts to 15 and stays there; non-watchdog build stays in state=1 with sdram_retry=0.
REQ-035 In RUN: sdram_init_done drops -> state=1, core_rst=1 next cycle.

Source files
------------

// File: rtl/snes_rst_seq.sv
// snes_rst_seq: power-up and reset sequencer for the SNES core.
// Sequence: POR -> SDRAM_INIT -> LOAD -> HOLD -> RUN. A debounced user button
// in RUN re-pulses the core reset. A ROM download in RUN parks the core in LOAD.
// Loss of SDRAM init in LOAD/HOLD/RUN falls back to SDRAM_INIT.
// Optional build macro RST_SEQ_WATCHDOG_EN: SDRAM_INIT times out after
// WDT_CYCLES and restarts from POR, counting restarts in sdram_retry
// (saturating at 15). Without the macro SDRAM_INIT waits forever and
// sdram_retry stays 0.
module snes_rst_seq #(
  parameter int POR_CYCLES      = 864000,
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 432000,
  parameter int WDT_CYCLES      = 8640000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdram_init_done,
  input  logic       loading,
  input  logic       btn_reset,
  output logic       sdram_rst,
  output logic       core_rst,
  output logic       core_ready,
  output logic [2:0] state,
  output logic [3:0] sdram_retry
);

  typedef enum logic [2:0] {
    ST_POR        = 3'd0,
    ST_SDRAM_INIT = 3'd1,
    ST_LOAD       = 3'd2,
    ST_HOLD       = 3'd3,
    ST_RUN        = 3'd4
  } state_t;

  // Terminal counts: a state lasting N cycles leaves when the counter reads N-1.
  localparam logic [23:0] POR_LAST  = 24'(POR_CYCLES - 1);
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] WDT_LAST  = 24'(WDT_CYCLES - 1);

`ifdef RST_SEQ_WATCHDOG_EN
  localparam logic WDT_EN = 1'b1;
`else
  localparam logic WDT_EN = 1'b0;
`endif

  // FSM registers
  state_t      r_state;
  logic [23:0] r_cnt;
  logic        r_sdram_rst;
  logic        r_core_rst;
  logic        r_core_ready;
  logic [3:0]  r_retry;

  // Button conditioning registers
  logic        r_sync1;
  logic        r_sync2;
  logic        r_db;
  logic [23:0] r_db_cnt;
  logic        r_press;

  // Next-state decode
  state_t      w_next;
  logic        w_wdt_fire;

  // Next-state selection; SDRAM loss has priority, then ROM load, then the button.
  always_comb begin
    w_next     = r_state;
    w_wdt_fire = 1'b0;
    case (r_state)
      ST_POR: begin
        if (r_cnt == POR_LAST) w_next = ST_SDRAM_INIT;
      end
      ST_SDRAM_INIT: begin
        if (sdram_init_done) begin
          w_next = ST_LOAD;
        end else if (WDT_EN && (r_cnt == WDT_LAST)) begin
          w_next     = ST_POR;
          w_wdt_fire = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!sdram_init_done) w_next = ST_SDRAM_INIT;
        else if (!loading)    w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!sdram_init_done)        w_next = ST_SDRAM_INIT;
        else if (r_cnt == HOLD_LAST) w_next = ST_RUN;
      end
      ST_RUN: begin
        // A press arriving together with a ROM load loses to the load.
        if (!sdram_init_done) w_next = ST_SDRAM_INIT;
        else if (loading)     w_next = ST_LOAD;
        else if (r_press)     w_next = ST_HOLD;
      end
      default: w_next = ST_POR;
    endcase
  end

  // State, per-state cycle counter, registered outputs and retry counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_POR;
      r_cnt        <= 24'd0;
      r_sdram_rst  <= 1'b1;
      r_core_rst   <= 1'b1;
      r_core_ready <= 1'b0;
      r_retry      <= 4'd0;
    end else begin
      r_state <= w_next;
      // Counter restarts on every state entry and sticks at full scale
      // so an indefinite wait never wraps into a false terminal count.
      if (w_next != r_state)      r_cnt <= 24'd0;
      else if (r_cnt != 24'hFFFFFF) r_cnt <= r_cnt + 24'd1;
      // Outputs are decoded from the next state so they line up with it.
      r_sdram_rst  <= (w_next == ST_POR);
      r_core_rst   <= (w_next != ST_RUN);
      r_core_ready <= (w_next == ST_RUN);
      if (w_wdt_fire && (r_retry != 4'hF)) r_retry <= r_retry + 4'd1;
    end
  end

  // Button: 2-flop synchroniser, stable-time debounce, one-cycle press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db     <= 1'b0;
      r_db_cnt <= 24'd0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= btn_reset;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_db) begin
        if (r_db_cnt == DEB_LAST) begin
          r_db     <= r_sync2;
          r_db_cnt <= 24'd0;
          // Only the debounced rising edge counts as a press.
          r_press  <= r_sync2;
        end else begin
          r_db_cnt <= r_db_cnt + 24'd1;
        end
      end else begin
        r_db_cnt <= 24'd0;
      end
    end
  end

  assign state       = r_state;
  assign sdram_rst   = r_sdram_rst;
  assign core_rst    = r_core_rst;
  assign core_ready  = r_core_ready;
  assign sdram_retry = r_retry;

endmodule

// File: tb/tb_snes_rst_seq.sv
// Bench for snes_rst_seq with small parameters. Stimulus is pushed through a
// behavioural model that predicts the output vector after every clock edge;
// a monitor pops and compares each prediction just after the edge.
module tb_snes_rst_seq;

  localparam int POR  = 16;
  localparam int HOLD = 8;
  localparam int DEB  = 4;
  localparam int WDT  = 64;

`ifdef RST_SEQ_WATCHDOG_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  // {state, sdram_rst, core_rst, core_ready, sdram_retry}
  localparam logic [9:0] RST_VEC = {3'd0, 1'b1, 1'b1, 1'b0, 4'd0};

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdram_init_done = 1'b0;
  logic       loading = 1'b0;
  logic       btn_reset = 1'b0;
  logic       sdram_rst;
  logic       core_rst;
  logic       core_ready;
  logic [2:0] state;
  logic [3:0] sdram_retry;

  always #5 clk = ~clk;

  snes_rst_seq #(
    .POR_CYCLES(POR),
    .HOLD_CYCLES(HOLD),
    .DEBOUNCE_CYCLES(DEB),
    .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sdram_init_done(sdram_init_done),
    .loading(loading),
    .btn_reset(btn_reset),
    .sdram_rst(sdram_rst),
    .core_rst(core_rst),
    .core_ready(core_ready),
    .state(state),
    .sdram_retry(sdram_retry)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  function automatic logic [9:0] dut_vec();
    return {state, sdram_rst, core_rst, core_ready, sdram_retry};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got state=%0d sdram_rst=%b core_rst=%b core_ready=%b retry=%0d, want state=%0d sdram_rst=%b core_rst=%b core_ready=%b retry=%0d",
               name, $time, act[9:7], act[6], act[5], act[4], act[3:0],
               exp[9:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs settle right after the edge; compare against the prediction.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check("scoreboard", dut_vec(), exp_q.pop_front());
  end

  // ---------------- reference model ----------------
  // Phase names: 0 POR, 1 SDRAM_INIT, 2 LOAD, 3 HOLD, 4 RUN.
  // Time in a phase is measured from the edge that entered it; the button is
  // judged over a sliding window of raw samples (two-edge synchroniser delay).
  int m_state = 0;
  int m_entry = 0;
  int m_cyc   = 0;
  int m_retry = 0;
  bit m_db    = 1'b0;
  bit m_press = 1'b0;
  bit h[$];

  task automatic model_step();
    int nxt;
    int t;
    bit flip;
    bit p;
    m_cyc++;
    if (rst) begin
      m_state = 0;
      m_entry = m_cyc;
      m_retry = 0;
      m_db    = 1'b0;
      m_press = 1'b0;
      h.delete();
      for (int k = 0; k < DEB + 2; k++) h.push_back(1'b0);
    end else begin
      p = m_press;
      // Level flips when the DEB samples seen through the synchroniser all disagree with it.
      flip = 1'b1;
      for (int k = 1; k <= DEB; k++) if (h[h.size() - 1 - k] == m_db) flip = 1'b0;
      m_press = flip && !m_db;
      if (flip) m_db = !m_db;
      h.push_back(btn_reset);
      if (h.size() > DEB + 2) void'(h.pop_front());
      t   = m_cyc - m_entry - 1;
      nxt = m_state;
      case (m_state)
        0: if (t == POR - 1) nxt = 1;
        1: begin
          if (sdram_init_done) nxt = 2;
          else if (WDT_EN && t == WDT - 1) begin
            nxt = 0;
            if (m_retry < 15) m_retry++;
          end
        end
        2: if (!sdram_init_done) nxt = 1; else if (!loading) nxt = 3;
        3: if (!sdram_init_done) nxt = 1; else if (t == HOLD - 1) nxt = 4;
        4: if (!sdram_init_done) nxt = 1; else if (loading) nxt = 2; else if (p) nxt = 3;
        default: nxt = 0;
      endcase
      if (nxt != m_state) begin
        m_state = nxt;
        m_entry = m_cyc;
      end
    end
    exp_q.push_back({3'(m_state), (m_state == 0), (m_state != 4), (m_state == 4), 4'(m_retry)});
  endtask

  // ---------------- driver ----------------
  // Drive inputs on the falling edge, predict, then return just after the rising edge.
  task automatic drive_cycle(input bit r, input bit d, input bit l, input bit b);
    @(negedge clk);
    rst             = r;
    sdram_init_done = d;
    loading         = l;
    btn_reset       = b;
    model_step();
    @(posedge clk);
    #2;
  endtask

  // Global time bound.
  initial begin
    #600000;
    $display("FAIL timeout: bench did not finish, got running, want finished");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int  t_sd;
    int  t_rdy;
    int  hold_at;
    int  hold_len;
    int  first_por;
    int  second_por;
    int  n_por;
    int  prev_state;
    int  b_run;
    int  l_run;
    bit  b;
    bit  l;
    bit  d;
    bit  r;

    // Reset and power-up timing
    drive_cycle(1, 1, 0, 0);
    drive_cycle(1, 1, 0, 0);
    check("reset_values", dut_vec(), RST_VEC);
    t_sd  = 0;
    t_rdy = 0;
    for (int i = 1; i <= 40; i++) begin
      drive_cycle(0, 1, 0, 0);
      if (t_sd == 0 && sdram_rst == 1'b0) t_sd = i;
      if (core_ready) begin
        t_rdy = i;
        break;
      end
    end
    check_int("por_to_sdram_init", t_sd, 16);
    check_int("por_to_run", t_rdy, 26);

    // Short press is filtered
    for (int i = 1; i <= 3; i++) drive_cycle(0, 1, 0, 1);
    for (int i = 1; i <= 12; i++) drive_cycle(0, 1, 0, 0);
    check_int("short_press_ignored", state, 4);

    // Long press: HOLD after DEB+3 cycles, core reset for HOLD cycles
    hold_at  = 0;
    hold_len = 0;
    for (int i = 1; i <= 30; i++) begin
      drive_cycle(0, 1, 0, i <= 10);
      if (hold_at == 0 && state == 3) hold_at = i;
      if (core_rst) hold_len++;
    end
    check_int("press_latency", hold_at, 7);
    check_int("hold_width", hold_len, 8);
    check_int("back_in_run", state, 4);

    // Load and press in the same cycle: load wins
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(0, 1, (i >= 7 && i <= 10), i <= 10);
      if (i == 7) check_int("load_wins_over_press", state, 2);
    end
    check_int("load_then_run", state, 4);

    // SDRAM init lost in RUN
    drive_cycle(0, 0, 0, 0);
    check_int("init_drop_state", state, 1);
    check_int("init_drop_core_rst", core_rst, 1);
    for (int i = 1; i <= 12; i++) drive_cycle(0, 1, 0, 0);
    check_int("recover_run", state, 4);

    // Asynchronous reset while in HOLD
    for (int i = 1; i <= 8; i++) drive_cycle(0, 1, 0, i <= 6);
    check_int("in_hold", state, 3);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", dut_vec(), RST_VEC);
    drive_cycle(1, 1, 0, 0);
    drive_cycle(1, 1, 0, 0);
    for (int i = 1; i <= 30; i++) drive_cycle(0, 1, 0, 0);
    check_int("restart_run", state, 4);

    // SDRAM never completes initialisation
    drive_cycle(1, 0, 0, 0);
    first_por  = 0;
    second_por = 0;
    n_por      = 0;
    prev_state = 0;
    for (int i = 1; i <= 17 * 80 + 10; i++) begin
      drive_cycle(0, 0, 0, 0);
      if (prev_state != 0 && state == 0) begin
        n_por++;
        if (first_por == 0) first_por = i;
        else if (second_por == 0) second_por = i;
      end
      prev_state = int'(state);
    end
`ifdef RST_SEQ_WATCHDOG_EN
    check_int("wdt_first_reentry", first_por, 80);
    check_int("wdt_period", second_por - first_por, 80);
    check_int("wdt_retry_saturated", sdram_retry, 15);
`else
    check_int("no_wdt_reentries", n_por, 0);
    check_int("no_wdt_state", state, 1);
    check_int("no_wdt_retry", sdram_retry, 0);
`endif

    // Randomised traffic
    drive_cycle(1, 1, 0, 0);
    b_run = 0;
    l_run = 0;
    b = 1'b0;
    l = 1'b0;
    d = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (b_run == 0) begin
        b     = 1'($urandom_range(0, 1));
        b_run = $urandom_range(1, 12);
      end
      b_run--;
      if (l_run == 0) begin
        l     = ($urandom_range(0, 5) == 0);
        l_run = $urandom_range(1, 20);
      end
      l_run--;
      d = d ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 499) == 0);
      drive_cycle(r, d, l, b);
    end
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 0);
    check_int("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
